// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage. Issues one instruction-memory request at a time
//   and presents fetched words to the IF/ID latch through an output register
//   backed by a one-entry skid buffer, so a stall never loses a returning word.
//   Redirects flush everything in flight and restart fetch at the new address.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     instruction memory request
//   imem_addr    fetch address, stable while imem_req=1 until imem_ack
//   imem_ack     memory response strobe (at most one per request)
//   imem_rdata   instruction word, valid with imem_ack
//   stall        IF/ID latch cannot accept this cycle
//   redirect     branch/jump taken: flush and refetch
//   redirect_pc  new fetch address when redirect=1 (forced word aligned)
//   pc_out       PC of the presented instruction
//   instr_out    presented instruction word
//   valid_out    pc_out/instr_out hold a live instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT, DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] hold_addr, hold_addr_next;
  logic [31:0] pc_next, instr_next;
  logic        valid_next;
  logic [31:0] skid_pc, skid_pc_next;
  logic [31:0] skid_instr, skid_instr_next;
  logic        skid_valid, skid_valid_next;
  logic        consume;
  logic [31:0] redirect_target;

  assign consume         = valid_out & ~stall;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // State register and all datapath storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      hold_addr  <= RESET_PC;
      pc_out     <= 32'h0000_0000;
      instr_out  <= 32'h0000_0000;
      valid_out  <= 1'b0;
      skid_pc    <= 32'h0000_0000;
      skid_instr <= 32'h0000_0000;
      skid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      hold_addr  <= hold_addr_next;
      pc_out     <= pc_next;
      instr_out  <= instr_next;
      valid_out  <= valid_next;
      skid_pc    <= skid_pc_next;
      skid_instr <= skid_instr_next;
      skid_valid <= skid_valid_next;
    end
  end

  // Next-state logic. In DISCARD an ack arriving together with another
  // redirect still ends the old request, so the FSM must leave DISCARD then
  // or it would wait forever for an ack that cannot come.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = FETCH;
      FETCH: begin
        if (redirect)
          state_next = imem_ack ? FETCH : DISCARD;
        else if (imem_ack && valid_out && !consume)
          state_next = WAIT_SLOT;
        else
          state_next = FETCH;
      end
      WAIT_SLOT: if (redirect || consume) state_next = FETCH;
      DISCARD:   if (imem_ack) state_next = FETCH;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath updates. The skid buffer only fills when a word returns while
  // the output register is occupied and not being consumed. A redirect
  // overrides everything: both entries are flushed and fetch restarts.
  always_comb begin
    fetch_pc_next   = fetch_pc;
    hold_addr_next  = hold_addr;
    pc_next         = pc_out;
    instr_next      = instr_out;
    valid_next      = valid_out;
    skid_pc_next    = skid_pc;
    skid_instr_next = skid_instr;
    skid_valid_next = skid_valid;

    case (state)
      FETCH: begin
        hold_addr_next = fetch_pc;
        if (consume) valid_next = 1'b0;
        if (imem_ack) begin
          if (!valid_out || consume) begin
            pc_next    = fetch_pc;
            instr_next = imem_rdata;
            valid_next = 1'b1;
          end else begin
            skid_pc_next    = fetch_pc;
            skid_instr_next = imem_rdata;
            skid_valid_next = 1'b1;
          end
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      WAIT_SLOT: begin
        if (consume) begin
          pc_next         = skid_pc;
          instr_next      = skid_instr;
          valid_next      = skid_valid;
          skid_valid_next = 1'b0;
        end
      end
      default: ;
    endcase

    if (redirect) begin
      valid_next      = 1'b0;
      skid_valid_next = 1'b0;
      fetch_pc_next   = redirect_target;
    end
  end

  // Outputs. DISCARD keeps presenting the abandoned address until its ack.
  always_comb begin
    imem_req  = (state == FETCH) || (state == DISCARD);
    imem_addr = (state == DISCARD) ? hold_addr : fetch_pc;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. A memory model answers requests
//   after a programmable delay with rdata = addr ^ 32'hA5A5_0000. Expected
//   PCs are queued as each scenario is driven and popped whenever the DUT
//   hands an instruction to the IF/ID latch. A second instance with a high
//   RESET_PC checks address wrap after reset.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  logic        imem_req_hi;
  logic [31:0] imem_addr_hi;
  logic        imem_ack_hi;
  logic [31:0] imem_rdata_hi;
  logic [31:0] pc_out_hi;
  logic [31:0] instr_out_hi;
  logic        valid_out_hi;

  int          mem_delay;
  int          wait_cnt;
  int          tests;
  int          fails;

  logic [31:0] exp_q[$];
  logic [31:0] hi_q[$];

  if_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .valid_out   (valid_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req_hi),
    .imem_addr   (imem_addr_hi),
    .imem_ack    (imem_ack_hi),
    .imem_rdata  (imem_rdata_hi),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0000_0000),
    .pc_out      (pc_out_hi),
    .instr_out   (instr_out_hi),
    .valid_out   (valid_out_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack once the request has waited mem_delay cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  assign imem_ack      = imem_req && (wait_cnt >= mem_delay);
  assign imem_rdata    = imem_addr ^ 32'hA5A5_0000;
  assign imem_ack_hi   = imem_req_hi;
  assign imem_rdata_hi = imem_addr_hi ^ 32'hA5A5_0000;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop an expected PC each time the latch takes an instruction.
  always @(negedge clk) begin
    if (rst_n && valid_out && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_instr", pc_out, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checkOutput("sb_pc", pc_out, e);
        checkOutput("sb_instr", instr_out, e ^ 32'hA5A5_0000);
      end
    end
    if (rst_n && valid_out_hi && hi_q.size() != 0) begin
      logic [31:0] h;
      h = hi_q.pop_front();
      checkOutput("hi_pc", pc_out_hi, h);
      checkOutput("hi_instr", instr_out_hi, h ^ 32'hA5A5_0000);
    end
  end

  // Stream until every queued PC has been taken, then stall (and optionally
  // redirect) in the first cycle nothing more is expected.
  task automatic drainQueue(input bit do_redirect, input logic [31:0] target);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus();
      if (exp_q.size() == 0) begin
        stall = 1'b1;
        if (do_redirect) begin
          checkOutput("redir_ack_same_cycle", {31'd0, imem_ack}, 32'd1);
          redirect    = 1'b1;
          redirect_pc = target;
        end
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_delay   = 0;
    hi_q.push_back(32'hFFFF_FFF8);
    hi_q.push_back(32'hFFFF_FFFC);
    hi_q.push_back(32'h0000_0000);

    // Reset values
    repeat (3) applyStimulus();
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_instr", instr_out, 32'h0);
    checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("rst_addr_hi", imem_addr_hi, 32'hFFFF_FFF8);

    // Zero-wait streaming from reset
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("first_req", {31'd0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    applyStimulus();
    checkOutput("lat_valid", {31'd0, valid_out}, 32'd1);
    checkOutput("lat_pc0", pc_out, 32'h0);
    applyStimulus();
    checkOutput("stream_pc4", pc_out, 32'h4);
    applyStimulus();
    checkOutput("stream_pc8", pc_out, 32'h8);
    checkOutput("stream_valid", {31'd0, valid_out}, 32'd1);

    // Three-cycle stall holding PC 8 while PC 12 sits in the skid buffer
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stall_hold_pc", pc_out, 32'h8);
      checkOutput("stall_hold_valid", {31'd0, valid_out}, 32'd1);
      checkOutput("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    stall     = 1'b0;
    mem_delay = 2;

    // Redirect while the request to 0x10 waits on a slow ack
    applyStimulus();
    checkOutput("slow_req_addr", imem_addr, 32'h10);
    applyStimulus();
    checkOutput("gap_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("slow_addr_held", imem_addr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    applyStimulus();
    redirect  = 1'b0;
    checkOutput("discard_req", {31'd0, imem_req}, 32'd1);
    checkOutput("discard_addr", imem_addr, 32'h10);
    mem_delay = 0;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    applyStimulus();
    checkOutput("redir_addr", imem_addr, 32'h100);
    checkOutput("redir_valid_low", {31'd0, valid_out}, 32'd0);

    // Redirect coincident with ack and stall
    drainQueue(1'b1, 32'h0000_0200);
    applyStimulus();
    redirect = 1'b0;
    checkOutput("flush_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("flush_req", {31'd0, imem_req}, 32'd1);
    checkOutput("flush_addr", imem_addr, 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    applyStimulus();
    applyStimulus();
    stall = 1'b0;

    // Fill both entries, then reset asynchronously from WAIT_SLOT
    drainQueue(1'b0, 32'h0);
    applyStimulus();
    checkOutput("full_wait_req", {31'd0, imem_req}, 32'd0);
    checkOutput("full_wait_pc", pc_out, 32'h20C);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("async_rst_pc", pc_out, 32'h0);
    checkOutput("async_rst_instr", instr_out, 32'h0);
    checkOutput("async_rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("async_rst_addr", imem_addr, 32'h0);
    applyStimulus();
    applyStimulus();
    stall = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    rst_n = 1'b1;
    drainQueue(1'b0, 32'h0);

    checkOutput("hi_seq_done", hi_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
